// File: rtl/adder_arbiter.sv
// ============================================================================
// Module   : adder_arbiter
// Purpose  : Round-robin arbiter sharing one signed ripple adder between two
//            requesters, with a registered valid/ready result channel and a
//            saturating overflow counter. Define ADDER_SAT_EN to saturate
//            RES_SUM on signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,
    input  logic             i_req0_cin,

    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,
    input  logic             i_req1_cin,

    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic             o_res_id,
    output logic [WIDTH-1:0] o_res_sum,
    output logic             o_res_carry,
    output logic             o_res_ovf,

    output logic [CNT_W-1:0] o_ovf_cnt,
    input  logic             i_cnt_clr
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [WIDTH-1:0] c_sat_pos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_sat_neg = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             r_state;
    logic               r_last;
    logic               r_id;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_free;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_accept;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH:0]     w_c;
    logic [WIDTH-1:0]   w_s;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_sum_out;

    // Reset gating keeps both READY low while rst_n is asserted.
    assign w_free   = rst_n & ((r_state == S_EMPTY) | i_res_ready);
    assign w_gnt0   = w_free & i_req0_valid & (~i_req1_valid | r_last);
    assign w_gnt1   = w_free & i_req1_valid & (~i_req0_valid | ~r_last);
    assign w_accept = w_gnt0 | w_gnt1;

    assign o_req0_ready = w_gnt0;
    assign o_req1_ready = w_gnt1;

    assign w_a    = w_gnt1 ? i_req1_a   : i_req0_a;
    assign w_b    = w_gnt1 ? i_req1_b   : i_req0_b;
    assign w_c[0] = w_gnt1 ? i_req1_cin : i_req0_cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
            assign w_s[gi]   = w_a[gi] ^ w_b[gi] ^ w_c[gi];
            assign w_c[gi+1] = (w_a[gi] & w_b[gi]) | (w_c[gi] & (w_a[gi] ^ w_b[gi]));
        end
    endgenerate

    // Sign test uses the operands and the final sum; carry-in only enters via the sum.
    assign w_ovf = (w_a[WIDTH-1] & w_b[WIDTH-1] & ~w_s[WIDTH-1]) |
                   (~w_a[WIDTH-1] & ~w_b[WIDTH-1] & w_s[WIDTH-1]);

`ifdef ADDER_SAT_EN
    assign w_sum_out = w_ovf ? (w_a[WIDTH-1] ? c_sat_neg : c_sat_pos) : w_s;
`else
    assign w_sum_out = w_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_state <= S_FULL;
                r_last  <= w_gnt1;
                r_id    <= w_gnt1;
                r_sum   <= w_sum_out;
                r_carry <= w_c[WIDTH];
                r_ovf   <= w_ovf;
            end else if ((r_state == S_FULL) && i_res_ready) begin
                r_state <= S_EMPTY;
            end

            if (i_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_accept && w_ovf && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_res_valid = (r_state == S_FULL);
    assign o_res_id    = r_id;
    assign o_res_sum   = r_sum;
    assign o_res_carry = r_carry;
    assign o_res_ovf   = r_ovf;
    assign o_ovf_cnt   = r_cnt;

endmodule

`default_nettype wire
